// File: rtl/seq_chk_pkg.sv
// Shared types and default sizing for the sequence checker.
// Holds the lock FSM state encoding and the default values of W, LOCK_N and ERR_W.
// No logic; imported by the interface, the successor function and the top.
package seq_chk_pkg;

    localparam int W_DEF      = 4;   // width of the sampled counter value
    localparam int LOCK_N_DEF = 3;   // consecutive matches needed to lock
    localparam int ERR_W_DEF  = 8;   // width of the saturating error counter

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_checker_if.sv
// Sample/status bundle between an upstream counter stage and the sequence checker.
// Ports: en, cnt (sample strobe and value, driven by master);
//        locked, fault, err_pulse, err_count, last_bad (status, driven by slave).
interface seq_checker_if import seq_chk_pkg::*; #(
    parameter int W     = W_DEF,
    parameter int ERR_W = ERR_W_DEF
);
    logic             en;
    logic [W-1:0]     cnt;
    logic             locked;
    logic             fault;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [W-1:0]     last_bad;

    modport master (
        output en, cnt,
        input  locked, fault, err_pulse, err_count, last_bad
    );

    modport slave (
        input  en, cnt,
        output locked, fault, err_pulse, err_count, last_bad
    );
endinterface

// File: rtl/seq_next.sv
// Successor function: the counter value expected to follow p.
// Latency: purely combinational. Backpressure: none.
// Ports: p (previous sample, W bits) -> exp (expected next sample, W bits).
// Build option: SEQ_CHK_JOHNSON_EN selects a Johnson successor; otherwise binary down-count.
module seq_next import seq_chk_pkg::*; #(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] p,
    output logic [W-1:0] exp
);

`ifdef SEQ_CHK_JOHNSON_EN
    // Shift left, feeding the inverted MSB back into bit 0.
    assign exp = {p[W-2:0], ~p[W-1]};
`else
    // Down-count; 0 wraps to all-ones naturally through modular subtraction.
    assign exp = p - W'(1);
`endif

endmodule

// File: rtl/seq_checker.sv
// Sequence checker: locks onto an upstream counter and counts sequence errors once locked.
// Latency: all status outputs are registered, 1 cycle after the sampling edge.
// Backpressure: none; every en=1 cycle is a sample and is always accepted.
// Ports: clk, rst (async, active-high); bus (seq_checker_if.slave):
//        en/cnt in; locked, fault, err_pulse, err_count, last_bad out.
// Build option: SEQ_CHK_JOHNSON_EN (passed through to seq_next) selects the successor rule.
module seq_checker import seq_chk_pkg::*; #(
    parameter int W      = W_DEF,
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int ERR_W  = ERR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    seq_checker_if.slave  bus
);

    localparam int                RUN_W   = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(LOCK_N);

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       prev;
    logic               prev_vld;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_nxt;
    logic [W-1:0]       exp_val;

    logic               cmp;
    logic               match;
    logic               mismatch;
    logic               err_hit;

    logic               locked_q;
    logic               fault_q;
    logic               err_pulse_q;
    logic [ERR_W-1:0]   err_count_q;
    logic [W-1:0]       last_bad_q;

    seq_next #(.W(W)) u_next (
        .p   (prev),
        .exp (exp_val)
    );

    // The very first sample after reset only seeds prev; it is neither a match nor a mismatch.
    assign cmp      = bus.en && prev_vld;
    assign match    = cmp && (bus.cnt == exp_val);
    assign mismatch = cmp && (bus.cnt != exp_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        err_hit   = 1'b0;

        if (match) begin
            run_nxt = (run == RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
        end else if (mismatch) begin
            run_nxt = '0;
        end

        unique case (state)
            HUNT: begin
                // Mismatches while hunting are expected and never counted.
                if (match && (run_nxt == RUN_MAX)) begin
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (mismatch) begin
                    state_nxt = FAULT;
                    err_hit   = 1'b1;
                end
            end
            FAULT: begin
                if (mismatch) begin
                    err_hit = 1'b1;
                end else if (match && (run_nxt == RUN_MAX)) begin
                    state_nxt = LOCK;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev        <= '0;
            prev_vld    <= 1'b0;
            run         <= '0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            last_bad_q  <= '0;
        end else begin
            // Status flags follow the next state so they appear with the same latency as the error data.
            locked_q    <= (state_nxt == LOCK);
            fault_q     <= (state_nxt == FAULT);
            err_pulse_q <= err_hit;

            if (bus.en) begin
                prev     <= bus.cnt;
                prev_vld <= 1'b1;
                run      <= run_nxt;
            end

            if (err_hit) begin
                if (err_count_q != '1) begin
                    err_count_q <= err_count_q + ERR_W'(1);
                end
                last_bad_q <= bus.cnt;
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.fault     = fault_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.last_bad  = last_bad_q;

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 The block SHALL have parameter W, default 4, the width of the sampled counter value.
REQ-002 The block SHALL have parameter LOCK_N, default 3, the number of consecutive matching samples needed to lock.
REQ-003 The block SHALL have parameter ERR_W, default 8, the width of the error counter.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port en, input, 1 bit: sample strobe; cnt is sampled only on clk edges where en=1.
REQ-007 Port cnt, input, W bits: the counter value produced by the upstream counter stage.
REQ-008 Port locked, output, 1 bit: high while the FSM is in LOCK.
REQ-009 Port fault, output, 1 bit: high while the FSM is in FAULT.
REQ-010 Port err_pulse, output, 1 bit: one-cycle pulse for each mismatch counted as an error.
REQ-011 Port err_count, output, ERR_W bits: the saturating count of errors.
REQ-012 Port last_bad, output, W bits: the value of cnt at the most recent counted error.

Function
REQ-013 The block SHALL hold prev (W bits), prev_vld, a run counter (0..LOCK_N), the FSM state, and the output registers.
REQ-014 The expected value SHALL be exp = next(prev), where next() is defined under Configuration.
REQ-015 A sample is en=1; it matches when prev_vld=1 and cnt==exp; every sample loads prev<=cnt and sets prev_vld<=1.
REQ-016 The first sample after reset (prev_vld=0) SHALL NOT be compared: no match, no mismatch, run unchanged.
REQ-017 On a match, run SHALL increment, saturating at LOCK_N; on a mismatch, run SHALL clear to 0.
REQ-018 FSM states: HUNT, LOCK, FAULT; the reset state is HUNT.
REQ-019 HUNT->LOCK on the sample that brings run to LOCK_N; mismatches in HUNT SHALL NOT count as errors.
REQ-020 LOCK stays in LOCK on a match; LOCK->FAULT on a mismatch, and that mismatch counts as an error.
REQ-021 FAULT->LOCK on the sample that brings run to LOCK_N; each further mismatch in FAULT counts as an error.
REQ-022 On a counted error, err_pulse=1 for exactly the next cycle, err_count increments (holding at 2^ERR_W-1), and last_bad<=cnt.
REQ-023 All outputs SHALL be registered, with 1-cycle latency from the sampling edge; en=0 cycles change nothing except clearing err_pulse.
REQ-024 Wrap-around (for example 0 -> 2^W-1 in down-count mode) SHALL be treated as a normal match.

Reset
REQ-025 While rst=1, independent of clk: state=HUNT, prev=0, prev_vld=0, run=0, locked=0, fault=0, err_pulse=0, err_count=0, last_bad=0.
REQ-026 Reset asserted mid-operation SHALL discard all history, and the first sample after release is treated per REQ-016.
REQ-027 A sample coincident with rst=1 SHALL be ignored.

Configuration
REQ-028 With macro SEQ_CHK_JOHNSON_EN defined, next(p) SHALL be the W-bit Johnson successor {p[W-2:0], ~p[W-1]}.
REQ-029 With SEQ_CHK_JOHNSON_EN undefined, next(p) SHALL be p-1 modulo 2^W (binary down-count).
REQ-030 All other behaviour SHALL be identical in both builds.

Structure
REQ-031 Package seq_chk_pkg SHALL hold the state enum (HUNT, LOCK, FAULT) and the default values of W, LOCK_N, and ERR_W.
REQ-032 Combinational sub-module seq_next (parameter W, input p, output exp) SHALL implement next() and contain the macro switch.
REQ-033 seq_checker SHALL instantiate seq_next exactly once.

Verification
REQ-034 Down mode, W=4: rst pulse, then samples 5,4,3,2 -> locked=1 the cycle after sample 2; err_count=0.
REQ-035 Down mode, locked on ...,1,0: samples 15,14 -> stays locked (wrap), no err_pulse.
REQ-036 Down mode, locked at prev=9: sample 3 -> fault=1, locked=0, err_pulse for one cycle, err_count=1, last_bad=3; then 2,1,0 -> locked=1.
REQ-037 Saturation, ERR_W=2: force 5 counted errors -> err_count stays at 3, and err_pulse still fires 5 times.
REQ-038 Johnson build: samples 0000,0001,0011,0111 -> locked=1; then sample 0101 -> fault=1, err_count=1.
REQ-039 Reset mid-operation: in FAULT with err_count=4, assert rst asynchronously between edges -> all outputs 0 immediately; the first sample after release is not compared.
